// File: rtl/lzc_seq_pkg.sv
// Shared types and helpers for the byte-serial leading-zero-count sequencer.
package lzc_seq_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} lzc_seq_state_e;

   localparam int CHUNK_W = 8;

   function automatic int cnt_width(int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/lzc_seq_ctrl_lzc_8.sv
// 8-bit leading-zero counter: cnt is the zero count, valid=0 for an all-zero byte.
module lzc_8 (
   input  logic [7:0] d,
   output logic [2:0] cnt,
   output logic       valid
);

   always_comb begin
      valid = (d != '0);
      cnt   = '0;
      casez (d)
         8'b1???????: cnt = 3'd0;
         8'b01??????: cnt = 3'd1;
         8'b001?????: cnt = 3'd2;
         8'b0001????: cnt = 3'd3;
         8'b00001???: cnt = 3'd4;
         8'b000001??: cnt = 3'd5;
         8'b0000001?: cnt = 3'd6;
         8'b00000001: cnt = 3'd7;
         default:     cnt = 3'd0;
      endcase
   end

endmodule

// File: rtl/lzc_seq_ctrl.sv
// Multi-cycle leading-zero-count sequencer, one byte per cycle, MSB first.
// Define LZC_SEQ_NORM_EN to build the normalised-operand output out_norm.
module lzc_seq_ctrl
   import lzc_seq_pkg::*;
#(
   parameter int DATA_W = 64,
   localparam int NCHUNK = DATA_W / CHUNK_W,
   localparam int CNT_W  = cnt_width(DATA_W),
   localparam int IDX_W  = $clog2(NCHUNK)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_zero
`ifdef LZC_SEQ_NORM_EN
   ,
   output logic [DATA_W-1:0] out_norm
`endif
);

   lzc_seq_state_e    state_q, state_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              zero_q, zero_d;

   logic [CHUNK_W-1:0] chunk;
   logic [2:0]         lz_cnt;
   logic               lz_valid;

   assign chunk = op_q[DATA_W-1-CHUNK_W*int'(idx_q) -: CHUNK_W];

   lzc_8 u_lzc_8 (
      .d     (chunk),
      .cnt   (lz_cnt),
      .valid (lz_valid)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush_i) begin
               op_d    = in_data;
               idx_d   = '0;
               acc_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (lz_valid) begin
               cnt_d   = acc_q + CNT_W'(lz_cnt);
               zero_d  = 1'b0;
               state_d = DONE;
            end else if (idx_q == IDX_W'(NCHUNK - 1)) begin
               cnt_d   = CNT_W'(DATA_W);
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               acc_d = acc_q + CNT_W'(CHUNK_W);
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (flush_i || out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

`ifdef LZC_SEQ_NORM_EN
   logic [DATA_W-1:0] norm_q, norm_d;

   // Shift by the final count on the SCAN->DONE edge; a shift of DATA_W yields zero.
   always_comb begin
      norm_d = norm_q;
      if (state_q == SCAN && state_d == DONE) norm_d = op_q << cnt_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) norm_q <= '0;
      else        norm_q <= norm_d;
   end

   assign out_norm = norm_q;
`endif

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign out_valid = (state_q == DONE);
   assign out_cnt   = cnt_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// Scoreboard bench for lzc_seq_ctrl at DATA_W=64; checks out_norm when LZC_SEQ_NORM_EN is defined.
module tb_lzc_seq_ctrl;

   localparam int DATA_W = 64;
   localparam int CNT_W  = 7;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush_i;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_cnt;
   logic              out_zero;
`ifdef LZC_SEQ_NORM_EN
   logic [DATA_W-1:0] out_norm;
`endif

   always #5 clk = ~clk;

   lzc_seq_ctrl #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cnt   (out_cnt),
      .out_zero  (out_zero)
`ifdef LZC_SEQ_NORM_EN
      ,
      .out_norm  (out_norm)
`endif
   );

   typedef struct {
      logic [63:0] cnt;
      logic [63:0] zero;
      logic [63:0] norm;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit-by-bit reference: count, zero flag, normalised value and byte-scan latency.
   function automatic exp_t model(input logic [63:0] d);
      exp_t e;
      int   n = 64;
      for (int i = 63; i >= 0; i--) begin
         if (d[i]) begin
            n = 63 - i;
            break;
         end
      end
      e.cnt  = 64'(n);
      e.zero = (n == 64) ? 64'd1 : 64'd0;
      e.norm = (n == 64) ? 64'd0 : (d << n);
      e.lat  = (n == 64) ? 8 : (n / 8) + 1;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         check("busy_in_ready", 64'(in_ready), 64'd0);
         tick();
         lat++;
      end
      if (!out_valid) check("valid_timeout", 64'(out_valid), 64'd1);
   endtask

   task automatic accept(input logic [63:0] d);
      check("idle_in_ready", 64'(in_ready), 64'd1);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_op(input logic [63:0] d, input int hold);
      exp_t        e;
      int          lat;
      logic [63:0] cnt_s, zero_s;
      sb.push_back(model(d));
      out_ready = 1'b0;
      accept(d);
      wait_valid(lat);
      e = sb.pop_front();
      check("latency", 64'(lat), 64'(e.lat));
      check("cnt", 64'(out_cnt), e.cnt);
      check("zero", 64'(out_zero), e.zero);
`ifdef LZC_SEQ_NORM_EN
      check("norm", out_norm, e.norm);
`endif
      cnt_s  = 64'(out_cnt);
      zero_s = 64'(out_zero);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_cnt", 64'(out_cnt), cnt_s);
         check("hold_zero", 64'(out_zero), zero_s);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_valid", 64'(out_valid), 64'd0);
      check("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      flush_i   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_cnt", 64'(out_cnt), 64'd0);
      check("rst_zero", 64'(out_zero), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", 64'(in_ready), 64'd1);

      run_op(64'h8000_0000_0000_0000, 0);
      run_op(64'h0000_1234_5678_9ABC, 0);
      run_op(64'h0000_0000_0000_0001, 0);
      run_op(64'h0000_0000_0000_0000, 0);
      run_op(64'h0000_00F0_0000_0000, 5);
      run_op(64'h0040_0000_0000_0000, 0);

      // flush on the 2nd SCAN cycle
      accept(64'h0000_0000_0000_0001);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_scan_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 8; i++) begin
         check("flush_scan_no_valid", 64'(out_valid), 64'd0);
         tick();
      end

      // flush together with in_valid in IDLE
      in_data  = 64'h8000_0000_0000_0000;
      in_valid = 1'b1;
      flush_i  = 1'b1;
      tick();
      in_valid = 1'b0;
      flush_i  = 1'b0;
      check("flush_idle_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_idle_no_valid", 64'(out_valid), 64'd0);
      end

      // flush drops a pending DONE result
      accept(64'h0100_0000_0000_0000);
      wait_valid(lat);
      check("flush_done_lat", 64'(lat), 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_done_valid", 64'(out_valid), 64'd0);
      check("flush_done_in_ready", 64'(in_ready), 64'd1);

      // reset while in DONE
      accept(64'h0000_1234_5678_9ABC);
      wait_valid(lat);
      check("pre_rst_cnt", 64'(out_cnt), 64'd19);
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_cnt", 64'(out_cnt), 64'd0);
      check("mid_rst_zero", 64'(out_zero), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
`ifdef LZC_SEQ_NORM_EN
      check("mid_rst_norm", out_norm, 64'd0);
`endif
      rst_n = 1'b1;
      tick();
      check("mid_rel_in_ready", 64'(in_ready), 64'd1);
      run_op(64'h0000_0000_0000_0100, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
